// File: rtl/spi_slave_frame_if.sv
// SPI pins plus the parallel TX/RX frame side of spi_slave_frame, bundled for port hookup.
// slave modport is the DUT view; master modport is the host/bench view.
interface spi_slave_frame_if #(
  parameter int RX_WIDTH = 88,
  parameter int TX_WIDTH = 40
);
  logic                sck;
  logic                ssel;
  logic                mosi;
  logic                miso;
  logic                miso_oe;
  logic [TX_WIDTH-1:0] tx_data;
  logic                tx_load;
  logic [RX_WIDTH-1:0] rx_data;
  logic                rx_valid;
  logic                frame_err;
  logic                busy;

  modport slave (
    input  sck, ssel, mosi, tx_data, tx_load,
    output miso, miso_oe, rx_data, rx_valid, frame_err, busy
  );

  modport master (
    output sck, ssel, mosi, tx_data, tx_load,
    input  miso, miso_oe, rx_data, rx_valid, frame_err, busy
  );
endinterface

// File: rtl/spi_slave_frame.sv
// SPI slave, fixed-length frames, any CPOL/CPHA; rx_valid/frame_err ~3-4 clk after the SCK/ssel edge.
// No backpressure: rx_data is overwritten by each full frame, tx_load may strike at any cycle.
module spi_slave_frame #(
  parameter int RX_WIDTH = 88,
  parameter int TX_WIDTH = 40,
  parameter bit CPOL     = 1'b0,
  parameter bit CPHA     = 1'b0
) (
  input logic              clk,
  input logic              rst,
  spi_slave_frame_if.slave bus
);
  localparam int CNT_W = $clog2(RX_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RX_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RX_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(RX_WIDTH + 1);

  typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_ACTIVE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_sck_sync;
  logic [2:0]          r_ssel_sync;
  logic [1:0]          r_mosi_sync;
  logic [1:0]          r_settle;
  logic [TX_WIDTH-1:0] r_shadow;
  logic [TX_WIDTH-1:0] r_tx_sh;
  logic                r_first;
  logic [RX_WIDTH-2:0] r_rx_sh;
  logic [CNT_W-1:0]    r_cnt;
  logic [RX_WIDTH-1:0] r_rx_data;
  logic                r_rx_valid;
  logic                r_frame_err;

  logic                w_sck_lead;
  logic                w_sck_trail;
  logic                w_ssel_fall;
  logic                w_ssel_rise;
  logic                w_sample_edge;
  logic                w_shift_edge;
  logic                w_settled;
  logic                w_start;
  logic                w_end;
  logic                w_active;
  logic                w_sample;
  logic                w_shift;
  logic [RX_WIDTH-1:0] w_rx_next;

  assign w_sck_lead    = (r_sck_sync[1] != CPOL) && (r_sck_sync[2] == CPOL);
  assign w_sck_trail   = (r_sck_sync[1] == CPOL) && (r_sck_sync[2] != CPOL);
  assign w_ssel_fall   = !r_ssel_sync[1] && r_ssel_sync[2];
  assign w_ssel_rise   = r_ssel_sync[1] && !r_ssel_sync[2];
  assign w_sample_edge = CPHA ? w_sck_trail : w_sck_lead;
  assign w_shift_edge  = CPHA ? w_sck_lead : w_sck_trail;
  // The ssel chain holds reset values, not pin samples, until three clocks have passed.
  assign w_settled     = (r_settle == 2'd3);
  assign w_rx_next     = {r_rx_sh, r_mosi_sync[1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ARM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    w_active    = 1'b0;
    w_sample    = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_ARM: begin
        if (w_settled && r_ssel_sync[1]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (w_ssel_fall) begin
          w_state_nxt = ST_ACTIVE;
          w_start     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        w_active = 1'b1;
        // ssel rising ends the frame and swallows any SCK edge seen in the same cycle.
        if (w_ssel_rise) begin
          w_state_nxt = ST_IDLE;
          w_end       = 1'b1;
        end else begin
          w_sample = w_sample_edge;
          w_shift  = w_shift_edge;
        end
      end
      default: begin
        w_state_nxt = ST_ARM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck_sync  <= {3{CPOL}};
      r_ssel_sync <= 3'b111;
      r_mosi_sync <= 2'b00;
      r_settle    <= 2'd0;
      r_shadow    <= '0;
      r_tx_sh     <= '0;
      r_first     <= 1'b0;
      r_rx_sh     <= '0;
      r_cnt       <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[1:0], bus.sck};
      r_ssel_sync <= {r_ssel_sync[1:0], bus.ssel};
      r_mosi_sync <= {r_mosi_sync[0], bus.mosi};
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;

      if (!w_settled) begin
        r_settle <= r_settle + 2'd1;
      end

      if (bus.tx_load) begin
        r_shadow <= bus.tx_data;
      end

      if (w_start) begin
        r_tx_sh <= bus.tx_load ? bus.tx_data : r_shadow;
        r_first <= 1'b1;
        r_cnt   <= '0;
      end else if (w_shift) begin
        r_first <= 1'b0;
        // With CPHA=1 the MSB is already on miso before the first leading edge.
        if (!(CPHA && r_first)) begin
          r_tx_sh <= {r_tx_sh[TX_WIDTH-2:0], 1'b0};
        end
      end

      if (w_sample) begin
        r_rx_sh <= w_rx_next[RX_WIDTH-2:0];
        if (r_cnt != CNT_SAT) begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (r_cnt == CNT_LAST) begin
          r_rx_data  <= w_rx_next;
          r_rx_valid <= 1'b1;
        end
      end

      if (w_end) begin
        r_frame_err <= (r_cnt != CNT_FULL);
      end
    end
  end

  assign bus.miso      = w_active & r_tx_sh[TX_WIDTH-1];
  assign bus.miso_oe   = w_active;
  assign bus.busy      = w_active;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_spi_slave_frame.sv
// Drives one SPI master timeline into four slaves (modes 0-3) and checks them against a frame-level model.
module tb_spi_slave_frame;
  localparam int RXW = 88;
  localparam int TXW = 40;
  localparam int HP  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ssel = 1'b1;
  logic           tx_load = 1'b0;
  logic [TXW-1:0] tx_data = '0;
  logic [3:0]     sck_v = 4'b1100;
  logic [3:0]     mosi_v = 4'b0000;
  logic [3:0]     miso_v, oe_v, busy_v, valid_v, err_v;
  logic [RXW-1:0] rxd_v [4];

  int checks = 0;
  int errors = 0;

  logic [RXW-1:0] m_rx_next = '0;
  logic [RXW-1:0] m_rx_last [4] = '{default: '0};
  int             m_valid_exp [4] = '{default: 0};
  int             m_valid_seen [4] = '{default: 0};
  int             m_err_exp [4] = '{default: 0};
  int             m_err_seen [4] = '{default: 0};
  logic [TXW-1:0] m_shadow = '0;
  logic [127:0]   miso_cap [4] = '{default: '0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_slave_frame_if #(.RX_WIDTH(RXW), .TX_WIDTH(TXW)) ifc ();
    assign ifc.sck     = sck_v[g];
    assign ifc.ssel    = ssel;
    assign ifc.mosi    = mosi_v[g];
    assign ifc.tx_data = tx_data;
    assign ifc.tx_load = tx_load;
    assign miso_v[g]   = ifc.miso;
    assign oe_v[g]     = ifc.miso_oe;
    assign busy_v[g]   = ifc.busy;
    assign valid_v[g]  = ifc.rx_valid;
    assign err_v[g]    = ifc.frame_err;
    assign rxd_v[g]    = ifc.rx_data;

    spi_slave_frame #(
      .RX_WIDTH(RXW),
      .TX_WIDTH(TXW),
      .CPOL(((g >> 1) & 1) != 0),
      .CPHA((g & 1) != 0)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc.slave)
    );
  end

  task automatic chk(input string name, input int m, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s mode%0d: got %0h expected %0h", name, m, act, exp);
    end
  endtask

  // Per-cycle comparison against the frame-level model.
  always @(negedge clk) begin
    if (rst) begin
      for (int m = 0; m < 4; m++) m_rx_last[m] = '0;
    end else begin
      for (int m = 0; m < 4; m++) begin
        if (valid_v[m]) begin
          m_valid_seen[m]++;
          chk("rx_valid_expected", m, 128'(m_valid_seen[m] <= m_valid_exp[m]), 128'd1);
          m_rx_last[m] = m_rx_next;
        end
        chk("rx_data", m, 128'(rxd_v[m]), 128'(m_rx_last[m]));
        if (err_v[m]) begin
          m_err_seen[m]++;
          chk("frame_err_expected", m, 128'(m_err_seen[m] <= m_err_exp[m]), 128'd1);
        end
        chk("oe_busy_idle_miso", m, {126'd0, oe_v[m], busy_v[m] ? 1'b0 : miso_v[m]},
            {126'd0, busy_v[m], 1'b0});
      end
    end
  end

  task automatic half_step(input int h, input logic [127:0] bits, input logic [127:0] exp_s);
    bit lead, samp, cpol, cpha;
    int b, nb;
    repeat (HP) @(posedge clk);
    #1;
    for (int m = 0; m < 4; m++) begin
      cpol = (m >= 2);
      cpha = ((m % 2) == 1);
      lead = ((h % 2) == 0);
      b    = h / 2;
      samp = (lead == !cpha);
      if (samp) begin
        miso_cap[m][127-b] = miso_v[m];
        chk("miso_bit", m, 128'(miso_v[m]), 128'(exp_s[127-b]));
      end
      sck_v[m] = lead ? ~cpol : cpol;
      if (!samp) begin
        nb = cpha ? b : b + 1;
        mosi_v[m] = (nb < 128) ? bits[127-nb] : 1'b0;
      end
    end
  endtask

  task automatic begin_frame(input logic [127:0] bits);
    for (int m = 0; m < 4; m++) begin
      miso_cap[m] = '0;
      mosi_v[m]   = ((m % 2) == 0) ? bits[127] : 1'b0;
    end
    @(posedge clk);
    #1 ssel = 1'b0;
  endtask

  task automatic end_frame();
    repeat (HP) @(posedge clk);
    #1 ssel = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    for (int m = 0; m < 4; m++) begin
      chk("rx_valid_count", m, 128'(m_valid_seen[m]), 128'(m_valid_exp[m]));
      chk("frame_err_count", m, 128'(m_err_seen[m]), 128'(m_err_exp[m]));
    end
  endtask

  // Bits are left-aligned in 'bits': the first bit on the wire is bits[127].
  task automatic run_frame(input logic [127:0] bits, input int n, input bit do_load, input logic [TXW-1:0] ld_val);
    logic [127:0] exp_s;
    exp_s = {(do_load ? ld_val : m_shadow), 88'd0};
    if (n >= RXW) begin
      m_rx_next = bits[127:40];
      for (int m = 0; m < 4; m++) m_valid_exp[m]++;
    end
    if (n != RXW) begin
      for (int m = 0; m < 4; m++) m_err_exp[m]++;
    end
    begin_frame(bits);
    if (do_load) begin
      // ssel low is seen as a falling edge on the third clock after it changes.
      repeat (2) @(posedge clk);
      #1 tx_load = 1'b1;
      tx_data  = ld_val;
      m_shadow = ld_val;
      @(posedge clk);
      #1 tx_load = 1'b0;
    end
    for (int h = 0; h < 2 * n; h++) half_step(h, bits, exp_s);
    end_frame();
  endtask

  task automatic load_shadow(input logic [TXW-1:0] v);
    @(posedge clk);
    #1 tx_load = 1'b1;
    tx_data = v;
    @(posedge clk);
    #1 tx_load = 1'b0;
    m_shadow = v;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] bits;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int m = 0; m < 4; m++) begin
      chk("reset_rx_data", m, 128'(rxd_v[m]), 128'd0);
      chk("reset_rx_valid", m, 128'(valid_v[m]), 128'd0);
      chk("reset_frame_err", m, 128'(err_v[m]), 128'd0);
      chk("reset_miso", m, 128'(miso_v[m]), 128'd0);
      chk("reset_miso_oe", m, 128'(oe_v[m]), 128'd0);
      chk("reset_busy", m, 128'(busy_v[m]), 128'd0);
    end

    // Full frame in all four modes.
    load_shadow(40'hA5_1234_5678);
    run_frame({88'hDEADBEEF_0123_4567_89AB_CD, 40'd0}, 88, 1'b0, 40'd0);
    for (int m = 0; m < 4; m++) begin
      chk("full_rx_literal", m, 128'(rxd_v[m]), 128'(88'hDEADBEEF_0123_4567_89AB_CD));
      chk("full_miso_literal", m, 128'(miso_cap[m][127:40]), 128'({40'hA5_1234_5678, 48'd0}));
    end

    // Short frame: error, rx_data untouched.
    run_frame({40'h11_2233_4455, 88'd0}, 40, 1'b0, 40'd0);
    for (int m = 0; m < 4; m++)
      chk("short_rx_kept", m, 128'(rxd_v[m]), 128'(88'hDEADBEEF_0123_4567_89AB_CD));

    // Long frame: first 88 bits delivered, error at end.
    run_frame({88'h1234_5678_9ABC_DEF0_1357_9B, 2'b10, 38'd0}, 90, 1'b0, 40'd0);
    for (int m = 0; m < 4; m++)
      chk("long_rx_literal", m, 128'(rxd_v[m]), 128'(88'h1234_5678_9ABC_DEF0_1357_9B));

    // Reset mid-frame with ssel held low.
    bits = {128{1'b1}};
    begin_frame(bits);
    for (int h = 0; h < 40; h++) half_step(h, bits, {m_shadow, 88'd0});
    @(posedge clk);
    #1 rst = 1'b1;
    m_shadow = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int h = 40; h < 200; h++) half_step(h, bits, 128'd0);
    for (int m = 0; m < 4; m++) begin
      chk("rst_mid_busy", m, 128'(busy_v[m]), 128'd0);
      chk("rst_mid_miso_oe", m, 128'(oe_v[m]), 128'd0);
    end
    end_frame();
    run_frame({88'hCAFE_F00D_1111_2222_3333_44, 40'd0}, 88, 1'b0, 40'd0);
    for (int m = 0; m < 4; m++) begin
      chk("rearm_rx_literal", m, 128'(rxd_v[m]), 128'(88'hCAFE_F00D_1111_2222_3333_44));
      chk("rearm_miso_zero", m, 128'(miso_cap[m][127:40]), 128'd0);
    end

    // tx_load coinciding with frame start bypasses the old shadow.
    load_shadow(40'h01_2345_6789);
    run_frame({88'hDEADBEEF_0123_4567_89AB_CD, 40'd0}, 88, 1'b1, 40'hFF_00FF_00FF);
    for (int m = 0; m < 4; m++) begin
      chk("load_start_miso_literal", m, 128'(miso_cap[m][127:40]), 128'({40'hFF_00FF_00FF, 48'd0}));
      chk("load_start_rx_literal", m, 128'(rxd_v[m]), 128'(88'hDEADBEEF_0123_4567_89AB_CD));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
